// File: rtl/ni_pkg.sv
// ni_pkg: shared definitions for the network-interface local injector.
//   ROUTE_*   : 4-bit route header codes placed in flit bits [WD-1:WD-4]
//   FLIT_WD   : default flit width, HDR_WD : route header width
//   inj_state_t : injector FSM states
package ni_pkg;

   localparam int unsigned FLIT_WD = 40;
   localparam int unsigned HDR_WD  = 4;

   localparam logic [HDR_WD-1:0] ROUTE_X     = 4'b0100;
   localparam logic [HDR_WD-1:0] ROUTE_Y     = 4'b1000;
   localparam logic [HDR_WD-1:0] ROUTE_LOCAL = 4'b0010;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      DRAIN
   } inj_state_t;

endpackage

// File: rtl/ni_route_calc.sv
// ni_route_calc: combinational XY route selection.
//   dest_x, dest_y in  CW      destination coordinates
//   route          out HDR_WD  X if dest_x differs from MY_X, else Y if dest_y
//                              differs from MY_Y, else LOCAL (loopback)
module ni_route_calc
   import ni_pkg::*;
#(
   parameter int unsigned CW   = 2,
   parameter int unsigned MY_X = 0,
   parameter int unsigned MY_Y = 0
) (
   input  logic [CW-1:0]     dest_x,
   input  logic [CW-1:0]     dest_y,
   output logic [HDR_WD-1:0] route
);

   localparam logic [CW-1:0] MX = CW'(MY_X);
   localparam logic [CW-1:0] MY = CW'(MY_Y);

   always_comb begin
      route = ROUTE_LOCAL;
      if (dest_x != MX) begin
         route = ROUTE_X;
      end else if (dest_y != MY) begin
         route = ROUTE_Y;
      end
   end

endmodule

// File: rtl/ni_local_injector.sv
// ni_local_injector: feeds the router local input port with flits
// {route, payload}. Route is computed once per packet descriptor; payload
// words stream through a one-entry output register at 1 flit/cycle.
//   wclk, rst_n                 clock, synchronous active-low reset
//   pkt_valid/pkt_ready         descriptor handshake (pkt_dest_x/y, pkt_len)
//   pld_valid/pld_ready         payload word handshake (pld_data)
//   full                        router local FIFO full (backpressure)
//   wr_en, wdata                flit write strobe and flit to router
//   busy                        packet in progress
//   err_len                     1-cycle pulse after a zero-length descriptor
// Optional: INJ_STALL_CNT_EN adds stall_cnt (saturating count of cycles where
// a flit was held back by full).
module ni_local_injector
   import ni_pkg::*;
#(
   parameter int unsigned WD   = FLIT_WD,
   parameter int unsigned CW   = 2,
   parameter int unsigned LW   = 4,
   parameter int unsigned MY_X = 0,
   parameter int unsigned MY_Y = 0
) (
   input  logic               wclk,
   input  logic               rst_n,
   input  logic               pkt_valid,
   output logic               pkt_ready,
   input  logic [CW-1:0]      pkt_dest_x,
   input  logic [CW-1:0]      pkt_dest_y,
   input  logic [LW-1:0]      pkt_len,
   input  logic               pld_valid,
   output logic               pld_ready,
   input  logic [WD-5:0]      pld_data,
   input  logic               full,
   output logic               wr_en,
   output logic [WD-1:0]      wdata,
   output logic               busy,
   output logic               err_len
`ifdef INJ_STALL_CNT_EN
   ,output logic [15:0]       stall_cnt
`endif
);

   inj_state_t        state_q, state_d;
   logic [HDR_WD-1:0] route, route_q;
   logic [WD-1:0]     flit_q;
   logic              fv_q;
   logic [LW-1:0]     remaining;
   logic              pkt_acc, pld_acc;

   ni_route_calc #(
      .CW   (CW),
      .MY_X (MY_X),
      .MY_Y (MY_Y)
   ) u_route (
      .dest_x (pkt_dest_x),
      .dest_y (pkt_dest_y),
      .route  (route)
   );

   // Handshakes are gated with rst_n so nothing moves while reset is held.
   assign wr_en   = rst_n & fv_q & ~full;
   assign wdata   = flit_q;
   assign busy    = (state_q != IDLE);
   assign pkt_acc = pkt_valid & pkt_ready;
   assign pld_acc = pld_valid & pld_ready;

   always_ff @(posedge wclk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      pkt_ready = 1'b0;
      pld_ready = 1'b0;
      case (state_q)
         IDLE: begin
            pkt_ready = rst_n;
            if (pkt_acc && (pkt_len != '0)) state_d = SEND;
         end
         SEND: begin
            // Refill the output register in the same cycle it drains.
            pld_ready = rst_n & (~fv_q | wr_en);
            if (pld_acc && (remaining == LW'(1))) state_d = DRAIN;
         end
         DRAIN: begin
            if (~fv_q | wr_en) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wclk) begin
      if (!rst_n) begin
         fv_q      <= 1'b0;
         flit_q    <= '0;
         route_q   <= '0;
         remaining <= '0;
         err_len   <= 1'b0;
      end else begin
         err_len <= pkt_acc & (pkt_len == '0);
         if (pkt_acc && (pkt_len != '0)) begin
            route_q   <= route;
            remaining <= pkt_len;
         end
         if (pld_acc) begin
            flit_q    <= {route_q, pld_data};
            fv_q      <= 1'b1;
            remaining <= remaining - LW'(1);
         end else if (wr_en) begin
            fv_q <= 1'b0;
         end
      end
   end

`ifdef INJ_STALL_CNT_EN
   always_ff @(posedge wclk) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (fv_q && full && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ni_local_injector.sv
module tb_ni_local_injector;

   localparam int unsigned WD   = 40;
   localparam int unsigned CW   = 2;
   localparam int unsigned LW   = 4;
   localparam int unsigned MY_X = 0;
   localparam int unsigned MY_Y = 0;

   logic          wclk = 1'b0;
   logic          rst_n = 1'b0;
   logic          pkt_valid = 1'b0;
   logic          pkt_ready;
   logic [CW-1:0] pkt_dest_x = '0;
   logic [CW-1:0] pkt_dest_y = '0;
   logic [LW-1:0] pkt_len = '0;
   logic          pld_valid = 1'b0;
   logic          pld_ready;
   logic [WD-5:0] pld_data = '0;
   logic          full = 1'b0;
   logic          wr_en;
   logic [WD-1:0] wdata;
   logic          busy;
   logic          err_len;
`ifdef INJ_STALL_CNT_EN
   logic [15:0]   stall_cnt;
`endif

   always #5 wclk = ~wclk;

   ni_local_injector #(
      .WD   (WD),
      .CW   (CW),
      .LW   (LW),
      .MY_X (MY_X),
      .MY_Y (MY_Y)
   ) dut (
      .wclk       (wclk),
      .rst_n      (rst_n),
      .pkt_valid  (pkt_valid),
      .pkt_ready  (pkt_ready),
      .pkt_dest_x (pkt_dest_x),
      .pkt_dest_y (pkt_dest_y),
      .pkt_len    (pkt_len),
      .pld_valid  (pld_valid),
      .pld_ready  (pld_ready),
      .pld_data   (pld_data),
      .full       (full),
      .wr_en      (wr_en),
      .wdata      (wdata),
      .busy       (busy),
      .err_len    (err_len)
`ifdef INJ_STALL_CNT_EN
      ,.stall_cnt (stall_cnt)
`endif
   );

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int cyc      = 0;

   // Transaction-level reference: words still owed by the core for the
   // current packet, and flits accepted but not yet written to the router.
   int            words_left = 0;
   logic [WD-1:0] exp_q[$];
   logic [WD-1:0] wlog[$];
   int            wcyc[$];
   bit            err_pend = 1'b0;
   logic [3:0]    cur_route = 4'b0;
   bit            pkt_acc, pld_acc;

   typedef struct {
      int          x, y, len;
      logic [35:0] base;
      logic [3:0]  route;
      logic [39:0] first;
      int          bp_at, bp_n;
   } vec_t;
   vec_t vt[5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [3:0] ref_route(input int x, input int y);
      if (x != int'(MY_X)) return 4'b0100;
      if (y != int'(MY_Y)) return 4'b1000;
      return 4'b0010;
   endfunction

   // Called just after a negedge with inputs already driven; checks the
   // outputs for this cycle, advances the model across the posedge.
   task automatic cycle();
      bit exp_wr, exp_pr, exp_lr;
      #1;
      pkt_acc = 1'b0;
      pld_acc = 1'b0;
      if (!rst_n) begin
         chk("rst_wr_en", 64'(wr_en), 64'd0);
         chk("rst_pkt_ready", 64'(pkt_ready), 64'd0);
         chk("rst_pld_ready", 64'(pld_ready), 64'd0);
         @(posedge wclk);
         exp_q.delete();
         words_left = 0;
         err_pend   = 1'b0;
      end else begin
         exp_wr = (exp_q.size() > 0) && !full;
         exp_pr = (words_left == 0) && (exp_q.size() == 0);
         exp_lr = (words_left > 0) && ((exp_q.size() == 0) || exp_wr);
         chk("wr_en", 64'(wr_en), 64'(exp_wr));
         chk("pkt_ready", 64'(pkt_ready), 64'(exp_pr));
         chk("pld_ready", 64'(pld_ready), 64'(exp_lr));
         chk("busy", 64'(busy), 64'(!exp_pr));
         chk("err_len", 64'(err_len), 64'(err_pend));
         if (exp_q.size() > 0 && (wr_en || full))
            chk(full ? "wdata_held" : "wdata", 64'(wdata), 64'(exp_q[0]));
         if (wr_en) begin
            wlog.push_back(wdata);
            wcyc.push_back(cyc);
         end
         @(posedge wclk);
         if (exp_wr) void'(exp_q.pop_front());
         err_pend = pkt_valid && exp_pr && (pkt_len == 0);
         if (pkt_valid && exp_pr) begin
            pkt_acc = 1'b1;
            if (pkt_len != 0) begin
               words_left = int'(pkt_len);
               cur_route  = ref_route(int'(pkt_dest_x), int'(pkt_dest_y));
            end
         end
         if (pld_valid && exp_lr) begin
            pld_acc = 1'b1;
            exp_q.push_back({cur_route, pld_data});
            words_left--;
         end
      end
      cyc++;
      @(negedge wclk);
   endtask

   task automatic send_pkt(input int x, input int y, input int len,
                           input logic [35:0] base, input int bp_at, input int bp_n);
      int sent  = 0;
      int guard = 0;
      int left  = bp_n;
      wlog.delete();
      wcyc.delete();
      pkt_dest_x = CW'(x);
      pkt_dest_y = CW'(y);
      pkt_len    = LW'(len);
      pkt_valid  = 1'b1;
      full       = 1'b0;
      do begin
         cycle();
         guard++;
      end while (!pkt_acc && guard < 20);
      chk("desc_accept", 64'(pkt_acc), 64'd1);
      pkt_valid = 1'b0;
      guard = 0;
      while ((sent < len || exp_q.size() > 0 || words_left > 0) && guard < 100) begin
         pld_valid = (sent < len);
         pld_data  = base + 36'(sent);
         if (bp_at >= 0 && wlog.size() == bp_at && left > 0) begin
            full = 1'b1;
            left--;
         end else begin
            full = 1'b0;
         end
         cycle();
         if (pld_acc) sent++;
         guard++;
      end
      pld_valid = 1'b0;
      full      = 1'b0;
      chk("pkt_done", 64'(guard < 100), 64'd1);
      cycle();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      int sent;
      logic [35:0] p;

      // Reset held for two edges.
      @(negedge wclk);
      cycle();
      cycle();
      chk("rst_wdata", 64'(wdata), 64'd0);
      chk("rst_wr_en_hold", 64'(wr_en), 64'd0);
      chk("rst_pkt_ready_hold", 64'(pkt_ready), 64'd0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_pkt_ready", 64'(pkt_ready), 64'd1);
      chk("post_rst_busy", 64'(busy), 64'd0);

      // Directed packets: single flit, burst, burst with backpressure,
      // loopback, maximum length.
      vt[0] = '{1, 0, 1,  36'h1,         4'b0100, 40'h40_0000_0001, -1, 0};
      vt[1] = '{0, 1, 4,  36'h1,         4'b1000, 40'h80_0000_0001, -1, 0};
      vt[2] = '{0, 1, 4,  36'h1,         4'b1000, 40'h80_0000_0001,  1, 2};
      vt[3] = '{0, 0, 3,  36'hABC00,     4'b0010, 40'h20_000A_BC00, -1, 0};
      vt[4] = '{3, 2, 15, 36'hF_FFFF_FFF0, 4'b0100, 40'h4F_FFFF_FFF0, -1, 0};
      for (int v = 0; v < 5; v++) begin
         send_pkt(vt[v].x, vt[v].y, vt[v].len, vt[v].base, vt[v].bp_at, vt[v].bp_n);
         chk("n_writes", 64'(wlog.size()), 64'(vt[v].len));
         if (wlog.size() == vt[v].len) begin
            chk("first_flit", 64'(wlog[0]), 64'(vt[v].first));
            for (int i = 0; i < vt[v].len; i++) begin
               p = vt[v].base + 36'(i);
               chk("flit_order", 64'(wlog[i]), 64'({vt[v].route, p}));
            end
            chk("write_span", 64'(wcyc[vt[v].len-1] - wcyc[0]),
                64'(vt[v].len - 1 + vt[v].bp_n));
         end
      end

      // Zero-length descriptor then a normal one.
      wlog.delete();
      pkt_dest_x = 2'd1; pkt_len = '0; pkt_valid = 1'b1;
      cycle();
      chk("zero_accept", 64'(pkt_acc), 64'd1);
      pkt_valid = 1'b0;
      cycle();
      cycle();
      chk("zero_no_write", 64'(wlog.size()), 64'd0);
      send_pkt(2, 3, 2, 36'h55, -1, 0);
      chk("after_zero_writes", 64'(wlog.size()), 64'd2);

      // Reset in the middle of a 4-flit packet.
      wlog.delete();
      pkt_dest_x = 2'd0; pkt_dest_y = 2'd1; pkt_len = 4'd4; pkt_valid = 1'b1;
      guard = 0;
      do begin cycle(); guard++; end while (!pkt_acc && guard < 20);
      pkt_valid = 1'b0;
      sent = 0; guard = 0;
      while (wlog.size() < 2 && guard < 20) begin
         pld_valid = 1'b1;
         pld_data  = 36'(sent + 1);
         cycle();
         if (pld_acc) sent++;
         guard++;
      end
      chk("mid_two_writes", 64'(wlog.size()), 64'd2);
      rst_n = 1'b0; pld_valid = 1'b0; full = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b1;
      #1;
      chk("mid_rst_wdata", 64'(wdata), 64'd0);
      chk("mid_rst_pkt_ready", 64'(pkt_ready), 64'd1);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      repeat (3) cycle();
      chk("mid_rst_no_stale", 64'(wlog.size()), 64'd2);

`ifdef INJ_STALL_CNT_EN
      chk("stall_cnt_reset", 64'(stall_cnt), 64'd0);
      full = 1'b1;
      pkt_dest_x = 2'd1; pkt_dest_y = 2'd1; pkt_len = 4'd1; pkt_valid = 1'b1;
      cycle();
      pkt_valid = 1'b0;
      pld_valid = 1'b1; pld_data = 36'h77;
      cycle();
      pld_valid = 1'b0;
      repeat (5) cycle();
      #1;
      chk("stall_cnt_five", 64'(stall_cnt), 64'd5);
      full = 1'b0;
      cycle();
      cycle();
`endif

      // Randomized traffic against the reference.
      for (int n = 0; n < 600; n++) begin
         pkt_valid  = ($urandom_range(0, 3) == 0);
         pkt_dest_x = CW'($urandom_range(0, 3));
         pkt_dest_y = CW'($urandom_range(0, 3));
         pkt_len    = LW'($urandom_range(0, 15));
         pld_valid  = ($urandom_range(0, 3) != 0);
         pld_data   = {4'($urandom), 32'($urandom)};
         full       = ($urandom_range(0, 9) < 3);
         cycle();
      end
      pkt_valid = 1'b0; full = 1'b0; pld_valid = 1'b1;
      guard = 0;
      while ((words_left > 0 || exp_q.size() > 0) && guard < 40) begin
         pld_data = {4'($urandom), 32'($urandom)};
         cycle();
         guard++;
      end
      pld_valid = 1'b0;
      chk("rand_drain", 64'(guard < 40), 64'd1);
      cycle();

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
